seq_frame_tx: RTL and testbench

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

---
 rtl/seq_frame_tx.sv | 134 +++++++++++++
 tb/tb_seq_frame_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_frame_tx
//  Description : Serial frame transmitter. Each accepted payload is sent as a
//                1101 sync word, the payload MSB first, then IDLE_GAP forced
//                zero cycles. All outputs decode from registered state only.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_tx #(
    parameter int PAYLOAD_W = 4,
    parameter int IDLE_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 data,
    output logic                 busy,
    output logic                 frame_done
);

    // One counter times every phase, so it must hold the longest phase length.
    localparam int c_CNT_MAX0 = (PAYLOAD_W > IDLE_GAP) ? PAYLOAD_W : IDLE_GAP;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > 4) ? c_CNT_MAX0 : 4;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SYNC_LOAD = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0] c_PAY_LOAD  = c_CNT_W'(PAYLOAD_W - 1);
    // With no gap this load value is never used; clamp it so it stays legal.
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    // Sync word indexed by the down-counter: cnt 3,2,1,0 -> 1,1,0,1.
    localparam logic [3:0] c_SYNC_PAT = 4'b1101;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SYNC    = 2'd1;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd2;
    localparam logic [1:0] c_ST_GAP     = 2'd3;

    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [PAYLOAD_W-1:0] r_shift;

    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [PAYLOAD_W-1:0] w_shift_nxt;
    logic                 w_cnt_zero;
    logic                 w_data;

    assign w_cnt_zero = (r_cnt == c_CNT_ZERO);

    // State, phase counter and payload shift register; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= c_CNT_ZERO;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: each phase ends when the counter reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            c_ST_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone means accept.
                if (in_valid) begin
                    w_state_nxt = c_ST_SYNC;
                    w_cnt_nxt   = c_SYNC_LOAD;
                    w_shift_nxt = in_data;
                end
            end
            c_ST_SYNC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_PAYLOAD;
                    w_cnt_nxt   = c_PAY_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_PAYLOAD: begin
                w_shift_nxt = r_shift << 1;
                if (w_cnt_zero) begin
                    if (IDLE_GAP > 0) begin
                        w_state_nxt = c_ST_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // Serial line decode: sync pattern, payload MSB, or forced zero.
    always_comb begin
        w_data = 1'b0;
        case (r_state)
            c_ST_SYNC:    w_data = c_SYNC_PAT[r_cnt[1:0]];
            c_ST_PAYLOAD: w_data = r_shift[PAYLOAD_W-1];
            default:      w_data = 1'b0;
        endcase
    end

    assign data       = w_data;
    assign in_ready   = (r_state == c_ST_IDLE);
    assign busy       = (r_state != c_ST_IDLE);
    assign frame_done = (r_state == c_ST_PAYLOAD) && w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_frame_tx
//  Description : Self-checking bench for seq_frame_tx. Two instances (4/2 and
//                8/0) are compared cycle by cycle against a frame-level model
//                that builds the expected serial stream as a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [3:0] in_data_a;
    logic [7:0] in_data_b;

    logic ready_a, data_a, busy_a, fd_a;
    logic ready_b, data_b, busy_b, fd_b;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle (data, frame_done) values for frames in flight.
    bit q_a_d[$];
    bit q_a_f[$];
    bit q_b_d[$];
    bit q_b_f[$];

    bit cur_busy_a, cur_busy_b;
    bit exp_d_a, exp_f_a, exp_d_b, exp_f_b;

    // Loopback 1101 detector state on instance A.
    logic [3:0] det_hist;
    bit         last_data_a;
    bit         det_armed;
    bit         acc_pending;
    int         first_acc_edge;
    int         edge_no = 0;

    always #5 clk = ~clk;

    seq_frame_tx #(.PAYLOAD_W(4), .IDLE_GAP(2)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data_a),
        .in_ready   (ready_a),
        .data       (data_a),
        .busy       (busy_a),
        .frame_done (fd_a)
    );

    seq_frame_tx #(.PAYLOAD_W(8), .IDLE_GAP(0)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data_b),
        .in_ready   (ready_b),
        .data       (data_b),
        .busy       (busy_b),
        .frame_done (fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame = sync 1101, payload MSB first (last bit flagged), IDLE_GAP zeros.
    task automatic push_frame_a(input logic [3:0] v);
        bit sync [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin q_a_d.push_back(sync[i]); q_a_f.push_back(1'b0); end
        for (int i = 3; i >= 0; i--) begin q_a_d.push_back(v[i]); q_a_f.push_back(i == 0); end
        for (int i = 0; i < 2; i++) begin q_a_d.push_back(1'b0); q_a_f.push_back(1'b0); end
    endtask

    task automatic push_frame_b(input logic [7:0] v);
        bit sync [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin q_b_d.push_back(sync[i]); q_b_f.push_back(1'b0); end
        for (int i = 7; i >= 0; i--) begin q_b_d.push_back(v[i]); q_b_f.push_back(i == 0); end
    endtask

    // Advance one clock: update the model with the inputs seen at the edge,
    // then compare both instances one time unit after the edge.
    task automatic step();
        @(posedge clk);
        edge_no++;
        if (!resetn) begin
            q_a_d.delete(); q_a_f.delete(); q_b_d.delete(); q_b_f.delete();
            cur_busy_a  = 1'b0;
            cur_busy_b  = 1'b0;
            det_hist    = 4'b0000;
            det_armed   = 1'b1;
            acc_pending = 1'b1;
        end else begin
            det_hist = {det_hist[2:0], last_data_a};
            if (in_valid && !cur_busy_a) begin
                push_frame_a(in_data_a);
                if (acc_pending) begin first_acc_edge = edge_no; acc_pending = 1'b0; end
            end
            if (in_valid && !cur_busy_b) push_frame_b(in_data_b);
        end
        if (q_a_d.size() > 0) begin
            exp_d_a = q_a_d.pop_front(); exp_f_a = q_a_f.pop_front(); cur_busy_a = 1'b1;
        end else begin
            exp_d_a = 1'b0; exp_f_a = 1'b0; cur_busy_a = 1'b0;
        end
        if (q_b_d.size() > 0) begin
            exp_d_b = q_b_d.pop_front(); exp_f_b = q_b_f.pop_front(); cur_busy_b = 1'b1;
        end else begin
            exp_d_b = 1'b0; exp_f_b = 1'b0; cur_busy_b = 1'b0;
        end
        #1;
        chk("a_data",  32'(data_a),  32'(exp_d_a));
        chk("a_fdone", 32'(fd_a),    32'(exp_f_a));
        chk("a_busy",  32'(busy_a),  32'(cur_busy_a));
        chk("a_ready", 32'(ready_a), 32'(!cur_busy_a));
        chk("b_data",  32'(data_b),  32'(exp_d_b));
        chk("b_fdone", 32'(fd_b),    32'(exp_f_b));
        chk("b_busy",  32'(busy_b),  32'(cur_busy_b));
        chk("b_ready", 32'(ready_b), 32'(!cur_busy_b));
        if (det_armed && det_hist == 4'b1101) begin
            det_armed = 1'b0;
            chk("det_latency", 32'(edge_no - first_acc_edge), 32'd4);
        end
        last_data_a = data_a;
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data_a   = 4'h0;
        in_data_b   = 8'h00;
        det_hist    = 4'b0000;
        last_data_a = 1'b0;
        det_armed   = 1'b1;
        acc_pending = 1'b1;
        first_acc_edge = 0;
        cur_busy_a  = 1'b0;
        cur_busy_b  = 1'b0;
        repeat (3) step();

        // First frame right after release: A sends 1010, B sends A5 with no gap.
        resetn    = 1'b1;
        in_valid  = 1'b1;
        in_data_a = 4'b1010;
        in_data_b = 8'hA5;
        step();
        in_valid = 1'b0;
        repeat (13) step();

        // Back-to-back frames with in_valid held high and data changing.
        in_valid  = 1'b1;
        in_data_a = 4'b0111;
        in_data_b = 8'h3C;
        step();
        in_data_a = 4'b1100;
        in_data_b = 8'hC3;
        repeat (24) step();
        in_valid = 1'b0;
        repeat (12) step();

        // Reset asserted mid-cycle during payload bit 2 of a frame.
        in_valid  = 1'b1;
        in_data_a = 4'b1111;
        in_data_b = 8'hFF;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        resetn = 1'b0;
        #3;
        chk("a_data_hold_before_edge", 32'(data_a), 32'(exp_d_a));
        chk("a_busy_hold_before_edge", 32'(busy_a), 32'(cur_busy_a));
        in_valid = 1'b1;
        step();
        step();
        // Accept must be possible on the very first edge after release.
        resetn    = 1'b1;
        in_data_a = 4'b0110;
        in_data_b = 8'h5A;
        step();
        in_valid = 1'b0;
        repeat (14) step();

        // Random traffic with in_data scrambled every cycle.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data_a = 4'($urandom);
            in_data_b = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (15) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
